jtdd_rom_arb: RTL and testbench

JTDD_ROM_ARB -- requirements
Module: jtdd_rom_arb

---
 rtl/jtdd_pkg.sv | 36 +++
 rtl/jtdd_rom_arb_if.sv | 27 ++
 rtl/jtdd_rom_slot.sv | 44 ++++
 rtl/jtdd_rom_arb.sv | 146 ++++++++++++++
 tb/tb_jtdd_rom_arb.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtdd_pkg.sv
// Shared constants, FSM encoding and the round-robin helper for the ROM arbiter.
package jtdd_pkg;

   localparam int NCLIENTS = 5;
   localparam int AW       = 22;
   localparam int DW       = 32;

   // Client indices
   localparam int MAIN = 0;
   localparam int MCU  = 1;
   localparam int CHAR = 2;
   localparam int SCR  = 3;
   localparam int OBJ  = 4;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_ACK  = 2'd1,
      WAIT_DATA = 2'd2
   } state_t;

   // First pending client found when walking forward from the one after 'last'.
   // The walk runs from the far end back, so the nearest pending client is
   // the one written last.
   function automatic logic [2:0] rr_next(input logic [NCLIENTS-1:0] pend,
                                          input logic [2:0]          last);
      logic [2:0] pick;
      int         idx;
      pick = last;
      for (int k = NCLIENTS; k >= 1; k--) begin
         idx = (int'(last) + k) % NCLIENTS;
         if (pend[idx]) pick = 3'(idx);
      end
      return pick;
   endfunction

endpackage

// File: rtl/jtdd_rom_arb_if.sv
// SDRAM-side request bus of the ROM arbiter.
// Handshake: the arbiter raises sdram_req with sdram_addr stable and holds both
// until the controller answers with a one-cycle sdram_ack; the request is
// accepted on that edge and sdram_req drops in the same edge. The read word
// comes later as a one-cycle data_rdy strobe with data_read valid alongside it.
// refresh_en tells the controller the arbiter has nothing to ask for.
interface jtdd_rom_arb_if;
   import jtdd_pkg::*;

   logic          sdram_req;
   logic [AW-1:0] sdram_addr;
   logic          sdram_ack;
   logic          data_rdy;
   logic [DW-1:0] data_read;
   logic          refresh_en;

   modport master (
      output sdram_req, sdram_addr, refresh_en,
      input  sdram_ack, data_rdy, data_read
   );

   modport slave (
      input  sdram_req, sdram_addr, refresh_en,
      output sdram_ack, data_rdy, data_read
   );

endinterface

// File: rtl/jtdd_rom_slot.sv
// One-entry read cache for a single ROM client: tag, data, valid and the
// registered ok flag.
module jtdd_rom_slot
   import jtdd_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          cs,
   input  logic [AW-1:0] addr,
   input  logic          we,
   input  logic [AW-1:0] wtag,
   input  logic [DW-1:0] wdata,
   output logic          hit,
   output logic          ok,
   output logic [DW-1:0] data
);

   logic          valid;
   logic [AW-1:0] tag;

   assign hit = valid && (tag == addr);

   // Cache entry update: clear wipes validity, a fill overrides any hit.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         tag   <= '0;
         data  <= '0;
         ok    <= 1'b0;
      end else if (clr) begin
         valid <= 1'b0;
         ok    <= 1'b0;
      end else begin
         ok <= cs && hit;
         if (we) begin
            tag   <= wtag;
            data  <= wdata;
            valid <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/jtdd_rom_arb.sv
// Five-client SDRAM ROM arbiter with a one-word cache per client, fixed or
// round-robin priority and a data-wait watchdog.
module jtdd_rom_arb
   import jtdd_pkg::*;
#(
   parameter int TOUT  = 63,
   parameter int PRIO0 = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   downloading,
   input  logic [NCLIENTS-1:0]    cs,
   input  logic [NCLIENTS*AW-1:0] addr,
   output logic [NCLIENTS*DW-1:0] dout,
   output logic [NCLIENTS-1:0]    ok,
   output logic                   ready,
   output state_t                 fsm_state,
   jtdd_rom_arb_if.master         sdram
);

   localparam int WDW = (TOUT < 2) ? 1 : $clog2(TOUT + 1);

   state_t                state, state_nxt;
   logic [2:0]            winner, rr_last, pick;
   logic                  pick_rr;
   logic                  req_r;
   logic [AW-1:0]         req_addr;
   logic [WDW-1:0]        wd;
   logic                  seen_idle;
   logic [NCLIENTS-1:0]   hit, pending;
   logic                  issue, take_ack, fill, wd_run;
   logic [AW-1:0]         addr_a [NCLIENTS];

   genvar g;
   generate
      for (g = 0; g < NCLIENTS; g++) begin : g_slot
         assign addr_a[g] = addr[g*AW +: AW];

         jtdd_rom_slot u_slot (
            .clk   (clk),
            .rst   (rst),
            .clr   (downloading),
            .cs    (cs[g]),
            .addr  (addr_a[g]),
            .we    (fill && (winner == 3'(g))),
            .wtag  (req_addr),
            .wdata (sdram.data_read),
            .hit   (hit[g]),
            .ok    (ok[g]),
            .data  (dout[g*DW +: DW])
         );
      end
   endgenerate

   assign pending          = cs & ~hit;
   assign sdram.sdram_req  = req_r && !downloading;
   assign sdram.sdram_addr = req_addr;
   assign sdram.refresh_en = (state == IDLE) && (pending == '0);
   assign ready            = !rst && !downloading && (seen_idle || state == IDLE);
   assign fsm_state        = state;

   // Winner selection: client 0 pre-empts the rotation when it has top priority.
   always_comb begin
      pick_rr = 1'b1;
      pick    = rr_next(pending, rr_last);
      if (PRIO0 != 0 && pending[MAIN]) begin
         pick    = 3'(MAIN);
         pick_rr = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic and the one-cycle control strobes for the datapath.
   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      take_ack  = 1'b0;
      fill      = 1'b0;
      wd_run    = 1'b0;
      case (state)
         IDLE: begin
            if (!downloading && pending != '0) begin
               state_nxt = WAIT_ACK;
               issue     = 1'b1;
            end
         end
         WAIT_ACK: begin
            // A request never accepted is dropped when a download starts.
            if (sdram.sdram_ack) begin
               state_nxt = WAIT_DATA;
               take_ack  = 1'b1;
            end else if (downloading) begin
               state_nxt = IDLE;
            end
         end
         WAIT_DATA: begin
            // Data arriving during a download completes the cycle but is not cached.
            if (sdram.data_rdy) begin
               state_nxt = IDLE;
               fill      = !downloading;
            end else if (wd == WDW'(TOUT - 1)) begin
               state_nxt = IDLE;
            end else begin
               wd_run = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request datapath: latch the winner, drive the request, run the watchdog.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_r    <= 1'b0;
         req_addr <= '0;
         winner   <= '0;
         rr_last  <= '0;
         wd       <= '0;
      end else begin
         if (issue) begin
            req_r    <= 1'b1;
            req_addr <= addr_a[pick];
            winner   <= pick;
            if (pick_rr) rr_last <= pick;
         end
         if (take_ack) begin
            req_r <= 1'b0;
            wd    <= '0;
         end
         if (wd_run) wd <= wd + 1'b1;
         if (state_nxt == IDLE) req_r <= 1'b0;
      end
   end

   // Remember that the arbiter has been idle since the last reset or download.
   always_ff @(posedge clk) begin
      if (rst || downloading)  seen_idle <= 1'b0;
      else if (state == IDLE)  seen_idle <= 1'b1;
   end

endmodule

// File: tb/tb_jtdd_rom_arb.sv
// Bench for jtdd_rom_arb: directed scenarios followed by randomized traffic,
// checked against a per-client cache model and a distance-based arbitration model.
module tb_jtdd_rom_arb;
   import jtdd_pkg::*;

   localparam int TOUT  = 63;
   localparam int PRIO0 = 1;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         downloading = 1'b0;
   logic [4:0]   cs = '0;
   logic [109:0] addr;
   logic [159:0] dout;
   logic [4:0]   ok;
   logic         ready;
   state_t       fsm_state;
   logic [21:0]  a [5];

   jtdd_rom_arb_if sd();

   jtdd_rom_arb #(.TOUT(TOUT), .PRIO0(PRIO0)) dut (
      .clk         (clk),
      .rst         (rst),
      .downloading (downloading),
      .cs          (cs),
      .addr        (addr),
      .dout        (dout),
      .ok          (ok),
      .ready       (ready),
      .fsm_state   (fsm_state),
      .sdram       (sd.master)
   );

   // Clock
   always #10 clk = ~clk;

   // Pack per-client addresses
   always_comb begin
      addr = '0;
      for (int i = 0; i < 5; i++) addr[i*22 +: 22] = a[i];
   end

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic        m_valid [5];
   logic [21:0] m_tag   [5];
   logic [31:0] m_data  [5];
   int          last_rr;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 5; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = '0;
         m_data[i]  = '0;
      end
      last_rr = 0;
   endtask

   function automatic logic [4:0] hit_vec();
      logic [4:0] h;
      for (int i = 0; i < 5; i++) h[i] = m_valid[i] && (m_tag[i] == a[i]);
      return h;
   endfunction

   function automatic logic [4:0] pend_vec();
      return cs & ~hit_vec();
   endfunction

   // Nearest pending client after the last round-robin winner, measured as a
   // forward distance modulo 5; client 0 short-circuits when it has priority.
   function automatic int pick_winner(input logic [4:0] p);
      int best;
      int bd;
      best = 0;
      bd   = 99;
      if (PRIO0 != 0 && p[0]) return 0;
      for (int i = 0; i < 5; i++) begin
         if (p[i]) begin
            int d;
            d = (i - last_rr + 4) % 5;
            if (d < bd) begin
               bd   = d;
               best = i;
            end
         end
      end
      return best;
   endfunction

   // Wait (bounded) for a request and check it targets the predicted winner.
   task automatic grant(input string tag, output int w, output logic [21:0] t);
      int n;
      n = 0;
      w = pick_winner(pend_vec());
      while (!sd.sdram_req && n < 40) begin
         step(1);
         n++;
      end
      chk({tag, "_req"}, 64'(sd.sdram_req), 64'(1));
      chk({tag, "_addr"}, 64'(sd.sdram_addr), 64'(a[w]));
      chk({tag, "_refresh"}, 64'(sd.refresh_en), 64'(0));
      t = a[w];
      if (PRIO0 == 0 || w != 0) last_rr = w;
   endtask

   // Acknowledge and complete a request, optionally with stray data_rdy in WAIT_ACK.
   task automatic finish_txn(input string tag, input int w, input logic [21:0] t,
                             input logic [31:0] d, input int ack_dly, input int data_dly,
                             input bit junk);
      repeat (ack_dly) begin
         if (junk) begin
            sd.data_rdy  = 1'b1;
            sd.data_read = $urandom;
         end
         step(1);
         sd.data_rdy = 1'b0;
      end
      sd.sdram_ack = 1'b1;
      step(1);
      sd.sdram_ack = 1'b0;
      chk({tag, "_req_drop"}, 64'(sd.sdram_req), 64'(0));
      chk({tag, "_wait_data"}, 64'(fsm_state), 64'(WAIT_DATA));
      step(data_dly);
      sd.data_rdy  = 1'b1;
      sd.data_read = d;
      step(1);
      sd.data_rdy  = 1'b0;
      chk({tag, "_idle"}, 64'(fsm_state), 64'(IDLE));
      m_valid[w] = 1'b1;
      m_tag[w]   = t;
      m_data[w]  = d;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      model_reset();
   endtask

   // Safety net against a stuck run
   initial begin
      #1000000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      int          w;
      logic [21:0] t;
      int          ord [5];
      logic [4:0]  p;
      logic [4:0]  hv;
      int          mode;
      int          guard;

      ord = '{1, 2, 3, 4, 1};
      sd.sdram_ack = 1'b0;
      sd.data_rdy  = 1'b0;
      sd.data_read = '0;
      for (int i = 0; i < 5; i++) a[i] = '0;
      model_reset();

      // Reset values
      step(2);
      chk("rst_ready_low", 64'(ready), 64'(0));
      chk("rst_req_low", 64'(sd.sdram_req), 64'(0));
      rst = 1'b0;
      step(1);
      chk("rst_req", 64'(sd.sdram_req), 64'(0));
      chk("rst_addr", 64'(sd.sdram_addr), 64'(0));
      chk("rst_ok", 64'(ok), 64'(0));
      chk("rst_dout_lo", dout[63:0], 64'(0));
      chk("rst_dout_hi", 64'(dout[159:64]), 64'(0));
      chk("rst_refresh", 64'(sd.refresh_en), 64'(1));
      chk("rst_ready", 64'(ready), 64'(1));
      chk("rst_state", 64'(fsm_state), 64'(IDLE));

      // Hit path on client 2
      a[2] = 22'h28010;
      cs   = 5'b00100;
      step(1);
      grant("hit_fill", w, t);
      finish_txn("hit_fill", w, t, 32'hA5A5_1234, 1, 2, 1'b0);
      chk("hit_ok_late", 64'(ok[2]), 64'(0));
      step(1);
      chk("hit_ok", 64'(ok[2]), 64'(1));
      chk("hit_dout", 64'(dout[95:64]), 64'(32'hA5A5_1234));
      chk("hit_noreq", 64'(sd.sdram_req), 64'(0));
      chk("hit_refresh", 64'(sd.refresh_en), 64'(1));

      // Client 0 beats client 4
      a[0] = 22'h11111;
      a[4] = 22'h04444;
      cs   = 5'b10001;
      step(1);
      grant("prio_first", w, t);
      chk("prio_first_main", 64'(sd.sdram_addr), 64'(22'h11111));
      finish_txn("prio_first", w, t, 32'h0000_1111, 0, 1, 1'b0);
      grant("prio_second", w, t);
      chk("prio_second_obj", 64'(sd.sdram_addr), 64'(22'h04444));
      finish_txn("prio_second", w, t, 32'h0000_4444, 2, 0, 1'b1);
      cs = '0;
      step(1);

      // Round-robin over clients 1..4
      do_reset();
      for (int i = 1; i < 5; i++) a[i] = 22'h21000 + 22'(i);
      cs = 5'b11110;
      step(1);
      for (int n = 0; n < 5; n++) begin
         grant("rr", w, t);
         chk("rr_order", 64'(sd.sdram_addr), 64'(a[ord[n]]));
         finish_txn("rr", w, t, 32'hC0DE_0000 + 32'(n), 1, 2, 1'b0);
         a[w] = a[w] + 22'h100;
      end
      cs = '0;
      step(1);

      // Watchdog
      a[3] = 22'h03330;
      cs   = 5'b01000;
      step(1);
      grant("wd", w, t);
      sd.sdram_ack = 1'b1;
      step(1);
      sd.sdram_ack = 1'b0;
      step(TOUT - 1);
      chk("wd_still_waiting", 64'(fsm_state), 64'(WAIT_DATA));
      step(1);
      chk("wd_idle", 64'(fsm_state), 64'(IDLE));
      chk("wd_req_low", 64'(sd.sdram_req), 64'(0));
      chk("wd_dout_kept", 64'(dout[127:96]), 64'(m_data[3]));
      chk("wd_ok_low", 64'(ok[3]), 64'(0));
      step(1);
      grant("wd_retry", w, t);
      finish_txn("wd_retry", w, t, 32'h3333_CAFE, 0, 3, 1'b0);
      step(1);
      chk("wd_hit_after", 64'(ok[3]), 64'(1));

      // Download
      a[1] = 22'h31111;
      a[2] = 22'h32222;
      cs   = 5'b01110;
      step(1);
      grant("dl_fill_a", w, t);
      finish_txn("dl_fill_a", w, t, 32'h1111_0001, 0, 1, 1'b0);
      grant("dl_fill_b", w, t);
      finish_txn("dl_fill_b", w, t, 32'h2222_0002, 0, 1, 1'b0);
      step(1);
      chk("dl_ok_before", 64'(ok), 64'(5'b01110));
      downloading = 1'b1;
      step(1);
      chk("dl_ok", 64'(ok), 64'(0));
      chk("dl_ready", 64'(ready), 64'(0));
      chk("dl_req", 64'(sd.sdram_req), 64'(0));
      step(9);
      chk("dl_ok_end", 64'(ok), 64'(0));
      chk("dl_ready_end", 64'(ready), 64'(0));
      chk("dl_req_end", 64'(sd.sdram_req), 64'(0));
      chk("dl_state_end", 64'(fsm_state), 64'(IDLE));
      downloading = 1'b0;
      for (int i = 0; i < 5; i++) m_valid[i] = 1'b0;
      step(1);
      chk("dl_ready_back", 64'(ready), 64'(1));
      chk("dl_first_miss", 64'(sd.sdram_req), 64'(1));
      guard = 0;
      while (pend_vec() != '0 && guard < 5) begin
         grant("dl_refill", w, t);
         finish_txn("dl_refill", w, t, $urandom, 0, 1, 1'b0);
         guard++;
      end
      cs = '0;
      step(1);

      // Reset in WAIT_DATA, then late data
      a[0] = 22'h0AAAA;
      cs   = 5'b00001;
      step(1);
      grant("rstmid", w, t);
      sd.sdram_ack = 1'b1;
      step(1);
      sd.sdram_ack = 1'b0;
      step(2);
      rst = 1'b1;
      cs  = '0;
      step(1);
      rst = 1'b0;
      model_reset();
      sd.data_rdy  = 1'b1;
      sd.data_read = 32'hDEAD_BEEF;
      step(1);
      sd.data_rdy = 1'b0;
      step(1);
      chk("rstmid_req", 64'(sd.sdram_req), 64'(0));
      chk("rstmid_addr", 64'(sd.sdram_addr), 64'(0));
      chk("rstmid_ok", 64'(ok), 64'(0));
      chk("rstmid_dout", 64'(dout[31:0]), 64'(0));
      chk("rstmid_state", 64'(fsm_state), 64'(IDLE));
      chk("rstmid_refresh", 64'(sd.refresh_en), 64'(1));
      chk("rstmid_ready", 64'(ready), 64'(1));
      cs = 5'b00001;
      step(1);
      grant("rstmid_miss", w, t);
      finish_txn("rstmid_miss", w, t, 32'h0A0A_0A0A, 1, 1, 1'b0);
      cs = '0;
      step(1);

      // Randomized traffic
      repeat (40) begin
         cs = 5'($urandom_range(0, 31));
         for (int i = 0; i < 5; i++) a[i] = 22'h1000 + 22'(i * 16) + 22'($urandom_range(0, 2));
         p  = pend_vec();
         hv = hit_vec() & cs;
         step(1);
         chk("rnd_ok", 64'(ok), 64'(hv));
         for (int i = 0; i < 5; i++) chk("rnd_dout", 64'(dout[i*32 +: 32]), 64'(m_data[i]));
         chk("rnd_req", 64'(sd.sdram_req), 64'(p != '0));
         if (p != '0) begin
            grant("rnd", w, t);
            mode = $urandom_range(0, 3);
            if (mode == 1) a[w] = a[w] ^ 22'h1;
            if (mode == 2) cs[w] = 1'b0;
            finish_txn("rnd", w, t, $urandom, $urandom_range(0, 3), $urandom_range(0, 5),
                       1'($urandom_range(0, 1)));
         end else begin
            chk("rnd_refresh", 64'(sd.refresh_en), 64'(1));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
